// File: rtl/audio_pkg.sv
// Shared types and constants for the game audio arbiter.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    GAP    = 2'd2,
    LOCKED = 2'd3
  } arb_state_t;

  // Requester indices; a higher index means a higher priority.
  localparam int SRC_JUMP = 0;
  localparam int SRC_DEAD = 1;
  localparam int SRC_WIN  = 2;

  // Clip codes presented to the playback engine.
  localparam logic [1:0] SEL_SILENT = 2'd0;
  localparam logic [1:0] SEL_JUMP   = 2'd1;
  localparam logic [1:0] SEL_DEAD   = 2'd2;
  localparam logic [1:0] SEL_WIN    = 2'd3;

endpackage

// File: rtl/audio_prio_enc.sv
// Highest-index-set priority encoder with a valid flag.
module audio_prio_enc #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_arbiter.sv
// Arbitrates game sound events onto the single pwm_top playback engine.
// Latches event pulses, grants the highest-priority pending event and
// sequences play, preemption gap, inter-sound gap, terminal lockout and a
// watchdog. audio_select must be wide enough that NUM_SRC+1 <= 2**SEL_W.
module audio_arbiter
  import audio_pkg::*;
#(
  parameter int                 NUM_SRC        = 3,
  parameter int                 SEL_W          = 2,
  parameter logic [NUM_SRC-1:0] TERMINAL_MASK  = 3'b110,
  parameter int                 GAP_CYCLES     = 1000,
  parameter int                 TIMEOUT_CYCLES = 100_000_000
) (
  input  logic               Clk,
  input  logic               reset_rtl_0,
  input  logic [NUM_SRC-1:0] req,
  input  logic               clear_lockout,
  input  logic               playback_complete,
  output logic               en,
  output logic [SEL_W-1:0]   audio_select,
  output logic               busy,
  output logic               locked,
  output logic               timeout_err
);

  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int MAX_CYC = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  arb_state_t         state_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [NUM_SRC-1:0] cand;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic [NUM_SRC-1:0] grant_mask;
  logic [NUM_SRC-1:0] cand_mask;
  logic               preempt;
  logic               wd_expire;
  logic               terminal;
  logic               cnt_sat;
  logic               gap_done;

  // One encoder serves both the IDLE grant and the PLAY preemption check.
  assign cand = pending_reg | req;

  audio_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .vec   (cand),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign grant_mask = NUM_SRC'(1) << grant_reg;
  assign cand_mask  = NUM_SRC'(1) << enc_idx;
  // Requests for the granted source are masked out of pending, so the
  // highest candidate exceeds the grant only when a higher source asks.
  assign preempt    = enc_valid && (enc_idx > grant_reg);
  assign wd_expire  = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign terminal   = TERMINAL_MASK[grant_reg];
  assign cnt_sat    = &cnt_reg;
  assign gap_done   = (cnt_reg == CNT_W'(GAP_CYCLES - 1));

  // Arbitration FSM with registered playback controls and status flags.
  always_ff @(posedge Clk or posedge reset_rtl_0) begin
    if (reset_rtl_0) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      grant_reg    <= '0;
      cnt_reg      <= '0;
      en           <= 1'b0;
      audio_select <= SEL_W'(SEL_SILENT);
      busy         <= 1'b0;
      locked       <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (clear_lockout) begin
      // Game restart: forget everything, including same-edge requests.
      state_reg    <= IDLE;
      pending_reg  <= '0;
      cnt_reg      <= '0;
      en           <= 1'b0;
      audio_select <= SEL_W'(SEL_SILENT);
      busy         <= 1'b0;
      locked       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (enc_valid) begin
            state_reg    <= PLAY;
            grant_reg    <= enc_idx;
            pending_reg  <= cand & ~cand_mask;
            en           <= 1'b1;
            audio_select <= SEL_W'(enc_idx) + SEL_W'(1);
            busy         <= 1'b1;
          end else begin
            pending_reg <= cand;
          end
        end

        PLAY: begin
          if (!cnt_sat) cnt_reg <= cnt_reg + CNT_W'(1);
          if (playback_complete || preempt || wd_expire) begin
            en           <= 1'b0;
            audio_select <= SEL_W'(SEL_SILENT);
            cnt_reg      <= '0;
            // Watchdog fires only when neither completion nor preemption won.
            if (!playback_complete && !preempt) timeout_err <= 1'b1;
            // Completion (real or forced) beats preemption; a terminal clip
            // locks out and discards everything still pending.
            if ((playback_complete || !preempt) && terminal) begin
              state_reg   <= LOCKED;
              locked      <= 1'b1;
              pending_reg <= '0;
            end else begin
              state_reg   <= GAP;
              pending_reg <= pending_reg | (req & ~grant_mask);
            end
          end else begin
            pending_reg <= pending_reg | (req & ~grant_mask);
          end
        end

        GAP: begin
          pending_reg <= cand;
          if (gap_done) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy      <= 1'b0;
          end else if (!cnt_sat) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        LOCKED: begin
          pending_reg <= '0;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_arbiter.sv
// Self-checking bench for audio_arbiter: table-driven vectors scored through
// an expected-result queue, plus hand sequences for watchdog and async reset.
module tb_audio_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst;
  logic [2:0] req_a, req_b;
  logic       clr_a, clr_b, cmp_a, cmp_b;
  logic       en_a, en_b, busy_a, busy_b, locked_a, locked_b, terr_a, terr_b;
  logic [1:0] sel_a, sel_b;

  // Terminal dead/win clips.
  audio_arbiter #(
    .NUM_SRC(3), .SEL_W(2), .TERMINAL_MASK(3'b110),
    .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut_a (
    .Clk(Clk), .reset_rtl_0(rst), .req(req_a), .clear_lockout(clr_a),
    .playback_complete(cmp_a), .en(en_a), .audio_select(sel_a),
    .busy(busy_a), .locked(locked_a), .timeout_err(terr_a)
  );

  // No terminal clips.
  audio_arbiter #(
    .NUM_SRC(3), .SEL_W(2), .TERMINAL_MASK(3'b000),
    .GAP_CYCLES(4), .TIMEOUT_CYCLES(20)
  ) dut_b (
    .Clk(Clk), .reset_rtl_0(rst), .req(req_b), .clear_lockout(clr_b),
    .playback_complete(cmp_b), .en(en_b), .audio_select(sel_b),
    .busy(busy_b), .locked(locked_b), .timeout_err(terr_b)
  );

  typedef struct {
    bit         b;
    logic [2:0] req;
    logic       clr;
    logic       cmp;
    logic [5:0] exp;  // {en, sel[1:0], busy, locked, timeout_err}
  } vec_t;

  typedef struct {
    int         id;
    bit         b;
    logic [5:0] out;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vid    = 0;

  function automatic vec_t mk(input bit b, input logic [2:0] r, input logic c,
                              input logic p, input logic e, input logic [1:0] s,
                              input logic bz, input logic l, input logic t);
    vec_t v;
    v.b   = b;
    v.req = r;
    v.clr = c;
    v.cmp = p;
    v.exp = {e, s, bz, l, t};
    return v;
  endfunction

  function automatic void add(input bit b, input logic [2:0] r, input logic c,
                              input logic p, input logic e, input logic [1:0] s,
                              input logic bz, input logic l, input logic t);
    vecs.push_back(mk(b, r, c, p, e, s, bz, l, t));
  endfunction

  task automatic expect_out(input bit b, input logic [5:0] o);
    exp_t x;
    x.id  = vid;
    x.b   = b;
    x.out = o;
    vid++;
    exp_q.push_back(x);
  endtask

  task automatic compare();
    exp_t       x;
    logic [5:0] got;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty queue, got nothing, required an entry");
      return;
    end
    x   = exp_q.pop_front();
    got = x.b ? {en_b, sel_b, busy_b, locked_b, terr_b}
              : {en_a, sel_a, busy_a, locked_a, terr_a};
    checks++;
    if (got !== x.out) begin
      errors++;
      $display("FAIL vec%0d dut_%s en/sel/busy/locked/terr: got %b required %b",
               x.id, x.b ? "b" : "a", got, x.out);
    end else begin
      $display("ok   vec%0d dut_%s en/sel/busy/locked/terr = %b",
               x.id, x.b ? "b" : "a", got);
    end
  endtask

  task automatic step(input vec_t v);
    req_a = v.b ? 3'b000 : v.req;
    clr_a = v.b ? 1'b0   : v.clr;
    cmp_a = v.b ? 1'b0   : v.cmp;
    req_b = v.b ? v.req  : 3'b000;
    clr_b = v.b ? v.clr  : 1'b0;
    cmp_b = v.b ? v.cmp  : 1'b0;
    expect_out(v.b, v.exp);
    @(posedge Clk);
    #1;
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_a = '0; req_b = '0;
    clr_a = 1'b0; clr_b = 1'b0; cmp_a = 1'b0; cmp_b = 1'b0;

    // Single jump, complete, 4-cycle gap, back to idle.
    add(0, 3'b001, 0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 3'b000, 0, 0, 1, 1, 1, 0, 0);
    add(0, 3'b000, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 3'b000, 0, 0, 0, 0, 1, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    // Simultaneous jump+dead: dead wins, locks, later jump ignored.
    add(0, 3'b011, 0, 0, 1, 2, 1, 0, 0);
    add(0, 3'b000, 0, 0, 1, 2, 1, 0, 0);
    add(0, 3'b000, 0, 1, 0, 0, 1, 1, 0);
    add(0, 3'b001, 0, 0, 0, 0, 1, 1, 0);
    add(0, 3'b000, 0, 0, 0, 0, 1, 1, 0);
    add(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    // Preemption of jump by win.
    add(0, 3'b001, 0, 0, 1, 1, 1, 0, 0);
    add(0, 3'b000, 0, 0, 1, 1, 1, 0, 0);
    add(0, 3'b100, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 3'b000, 0, 0, 0, 0, 1, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 1, 3, 1, 0, 0);
    add(0, 3'b000, 0, 1, 0, 0, 1, 1, 0);
    add(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    // Queued jump dropped by terminal dead completion.
    add(0, 3'b010, 0, 0, 1, 2, 1, 0, 0);
    add(0, 3'b001, 0, 0, 1, 2, 1, 0, 0);
    add(0, 3'b000, 0, 0, 1, 2, 1, 0, 0);
    add(0, 3'b000, 0, 1, 0, 0, 1, 1, 0);
    add(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    // Non-terminal completion beats same-cycle win request; win kept.
    add(0, 3'b001, 0, 0, 1, 1, 1, 0, 0);
    add(0, 3'b100, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 3'b000, 0, 0, 0, 0, 1, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 1, 3, 1, 0, 0);
    add(0, 3'b000, 0, 1, 0, 0, 1, 1, 0);
    add(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    // Terminal completion beats same-cycle win request; win dropped.
    add(0, 3'b010, 0, 0, 1, 2, 1, 0, 0);
    add(0, 3'b100, 0, 1, 0, 0, 1, 1, 0);
    add(0, 3'b000, 0, 0, 0, 0, 1, 1, 0);
    add(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    // clear_lockout drops a same-edge request.
    add(0, 3'b001, 1, 0, 0, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    // No terminal sources: queued jump plays after the gap.
    add(1, 3'b010, 0, 0, 1, 2, 1, 0, 0);
    add(1, 3'b001, 0, 0, 1, 2, 1, 0, 0);
    add(1, 3'b000, 0, 0, 1, 2, 1, 0, 0);
    add(1, 3'b000, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 3'b000, 0, 0, 0, 0, 1, 0, 0);
    add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3'b000, 0, 0, 1, 1, 1, 0, 0);
    add(1, 3'b000, 0, 1, 0, 0, 1, 0, 0);

    // Reset state.
    #12;
    expect_out(0, 6'b000000);
    compare();
    expect_out(1, 6'b000000);
    compare();
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // Watchdog: jump never completes; expires at the 20th PLAY cycle.
    step(mk(0, 3'b001, 0, 0, 1, 1, 1, 0, 0));
    for (int i = 0; i < 19; i++) step(mk(0, 3'b000, 0, 0, 1, 1, 1, 0, 0));
    step(mk(0, 3'b000, 0, 0, 0, 0, 1, 0, 1));
    for (int i = 0; i < 3; i++) step(mk(0, 3'b000, 0, 0, 0, 0, 1, 0, 1));
    step(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1));
    step(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 1));

    // Async reset mid-PLAY with a jump pending; no replay afterwards.
    step(mk(0, 3'b010, 0, 0, 1, 2, 1, 0, 1));
    step(mk(0, 3'b001, 0, 0, 1, 2, 1, 0, 1));
    req_a = 3'b000;
    #3;
    rst = 1'b1;
    #1;
    expect_out(0, 6'b000000);
    compare();
    @(posedge Clk);
    #1;
    expect_out(0, 6'b000000);
    compare();
    #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_arbiter.md
Name: audio_arbiter

Overview:
- Shares the single `pwm_top` playback engine between game sound-event requesters (jump, dead, win).
- Latches one-cycle event pulses and grants the highest-priority pending event.
- Drives `en`/`audio_select` into `pwm_top` and sequences start, preemption, inter-sound gap, terminal lockout and a watchdog.
- Sits between game logic and `pwm_top`.

Parameters:
- NUM_SRC, 3, number of requesters; index 0=jump, 1=dead, 2=win; higher index = higher priority.
- SEL_W, 2, width of audio_select; must satisfy NUM_SRC+1 <= 2**SEL_W.
- TERMINAL_MASK, 3'b110, sources that enter lockout on completion (dead, win).
- GAP_CYCLES, 1000, silent cycles (en=0) between sounds and on preemption; minimum 1.
- TIMEOUT_CYCLES, 100_000_000, maximum PLAY cycles before a forced stop (2 s at 50 MHz).

Ports:
- Clk  in  1  system clock.
- reset_rtl_0  in  1  asynchronous active-high reset.
- req  in  NUM_SRC  per-source event pulse, sampled each rising edge.
- clear_lockout  in  1  game restart; clears lockout and all pending events.
- playback_complete  in  1  from pwm_top; clip finished, valid only while en=1.
- en  out  1  playback enable to pwm_top.
- audio_select  out  SEL_W  clip code: 0=silent, granted index+1 otherwise.
- busy  out  1  high in any state other than IDLE.
- locked  out  1  high in LOCKED.
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; pending=0; counters=0; en=0; audio_select=0; busy=0; locked=0; timeout_err=0. Reset mid-playback aborts silently.
- All outputs are registered.
- States:
  - IDLE: en=0, audio_select=0.
  - PLAY: en=1, audio_select=grant+1.
  - GAP: en=0, audio_select=0.
  - LOCKED: en=0, audio_select=0.
- pending[i] is set on any edge where req[i]=1 and the request is not dropped. It is cleared when source i is granted.
- IDLE:
  - cand = pending | req.
  - If cand != 0: grant = highest set index; the state is PLAY at the next edge.
  - Latency is 1 cycle: req sampled at edge k gives en=1 after edge k.
  - The watchdog counter loads 0.
- PLAY:
  - Watchdog increments each cycle.
  - Requests for the granted source are dropped.
  - Lower-priority requests are held pending.
  - playback_complete=1: if TERMINAL_MASK[grant] then go to LOCKED, else go to GAP.
  - Else, a request or pending bit with index > grant means preemption. Go to GAP; the preempting source stays pending. The interrupted source is not re-queued.
  - Else, watchdog == TIMEOUT_CYCLES-1: set timeout_err. Then handle exactly as playback_complete.
- Same cycle in PLAY: completion beats preemption. A terminal completion drops the higher request; a non-terminal completion goes to GAP with the request kept pending.
- GAP:
  - Counter runs from 0 to GAP_CYCLES-1, then the state returns to IDLE.
  - Requests are latched into pending.
  - The gap guarantees pwm_top sees en=0 for at least GAP_CYCLES cycles, so its clip restarts cleanly.
- LOCKED:
  - Requests are dropped and pending is held at 0.
  - Only clear_lockout leaves this state (to IDLE).
- clear_lockout in any state:
  - Next state is IDLE and pending=0.
  - Requests on the same edge are dropped.
  - Priority: clear_lockout beats every other event except reset.
- playback_complete is ignored outside PLAY.
- Counters are sized $clog2(max(GAP_CYCLES, TIMEOUT_CYCLES))+1. They saturate and do not wrap.

Decomposition:
- Package audio_pkg:
  - arb_state_t enum {IDLE, PLAY, GAP, LOCKED}.
  - Source indices SRC_JUMP=0, SRC_DEAD=1, SRC_WIN=2.
  - Select codes SEL_SILENT=0, SEL_JUMP=1, SEL_DEAD=2, SEL_WIN=3.
- One sub-module: audio_prio_enc (parameterised NUM_SRC).
  - Combinational highest-index-set encoder with a valid flag.
  - Used for the IDLE grant and for the preemption compare.
- Top instantiates audio_arbiter feeding pwm_top.

Test Plan (overrides GAP_CYCLES=4, TIMEOUT_CYCLES=20):
- Single jump: req=3'b001 for 1 cycle in IDLE -> en=1 and audio_select=1 the next cycle. Drive playback_complete at cycle 6 -> en=0 for 4 cycles, then IDLE, busy=0.
- Simultaneous: req=3'b011 -> audio_select=2 (dead). Complete -> locked=1. A later req=3'b001 is ignored. clear_lockout -> IDLE with no jump played (pending cleared).
- Preemption: jump playing, then req=3'b100 -> en=0 next cycle for 4 cycles, then audio_select=3 (win). Complete -> LOCKED.
- Queueing: dead playing, jump pulse mid-play -> after dead completes the state is LOCKED and jump is dropped. Repeat with TERMINAL_MASK=0 -> jump plays after the 4-cycle gap.
- Watchdog: grant jump, never assert complete -> at PLAY cycle 20 timeout_err=1 (sticky), GAP, then IDLE.
- Async reset asserted mid-PLAY between clock edges -> en=0, audio_select=0, timeout_err=0 immediately. After release, no replay of the pre-reset pending request.
